// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   Issue controller that sits between decode and execute. It holds one
//   decoded instruction in an issue slot. A per-register counter scoreboard
//   tracks writes that are in flight. The held instruction goes to execute
//   only when its sources are free, its destination counter has room, and
//   execute is ready. The block also handles flush and counts stall cycles.
//
//   Optional feature: define WB_BYPASS_EN so that a source whose counter is 1
//   counts as free in the cycle its writeback retires. Execute forwards the
//   value in that cycle.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready   decoded instruction handshake
//   in_ra1/in_ra2       source registers, qualified by in_use_ra1/in_use_ra2
//   in_wen/in_dst       destination write enable / register
//   out_valid/out_ready issue handshake towards execute
//   wb_valid/wb_dst     one retiring register write per cycle
//   flush               drop the held, not yet issued instruction
//   hazard              held instruction is blocked by the scoreboard
//   stall_cycles        count of cycles with a held instruction not issued
module decode_issue_ctrl #(
   parameter int CNT_W  = 2,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_ra1,
   input  logic [4:0]        in_ra2,
   input  logic              in_use_ra1,
   input  logic              in_use_ra2,
   input  logic              in_wen,
   input  logic [4:0]        in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              wb_valid,
   input  logic [4:0]        wb_dst,
   input  logic              flush,
   output logic              hazard,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HELD  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]        state_reg;
   logic [4:0]        ra1_reg;
   logic [4:0]        ra2_reg;
   logic              use_ra1_reg;
   logic              use_ra2_reg;
   logic              wen_reg;
   logic [4:0]        dst_reg;
   logic [PERF_W-1:0] stall_reg;
   logic [CNT_W-1:0]  cnt_reg [0:31];

   logic              held;
   logic              issue;
   logic              accept;
   logic [CNT_W-1:0]  cnt_ra1;
   logic [CNT_W-1:0]  cnt_ra2;
   logic [CNT_W-1:0]  cnt_dst;
   logic              wb_hit_ra1;
   logic              wb_hit_ra2;
   logic              ra1_busy;
   logic              ra2_busy;
   logic              dst_block;
   logic [31:0]       inc_vec;
   logic [31:0]       dec_vec;

   assign held    = (state_reg == ST_HELD);
   assign cnt_ra1 = cnt_reg[ra1_reg];
   assign cnt_ra2 = cnt_reg[ra2_reg];
   assign cnt_dst = cnt_reg[dst_reg];

`ifdef WB_BYPASS_EN
   // The last outstanding write retires this cycle. Execute picks the
   // value off the writeback path, so the consumer need not wait.
   assign wb_hit_ra1 = wb_valid && (wb_dst == ra1_reg) && (cnt_ra1 == CNT_ONE);
   assign wb_hit_ra2 = wb_valid && (wb_dst == ra2_reg) && (cnt_ra2 == CNT_ONE);
`else
   assign wb_hit_ra1 = 1'b0;
   assign wb_hit_ra2 = 1'b0;
`endif

   assign ra1_busy  = use_ra1_reg && (ra1_reg != 5'd0) && (cnt_ra1 != '0) && !wb_hit_ra1;
   assign ra2_busy  = use_ra2_reg && (ra2_reg != 5'd0) && (cnt_ra2 != '0) && !wb_hit_ra2;
   // A saturated counter cannot record one more in-flight write.
   assign dst_block = wen_reg && (dst_reg != 5'd0) && (cnt_dst == CNT_MAX);

   assign hazard    = held && (ra1_busy || ra2_busy || dst_block);
   assign out_valid = held && !hazard && !flush;
   assign issue     = out_valid && out_ready;
   // Combinational ready lets a new instruction enter in the cycle the
   // held one leaves, so a full pipeline has no bubble.
   assign in_ready  = !flush && (!held || issue);
   assign accept    = in_valid && in_ready;

   assign stall_cycles = stall_reg;

   // Per-register increment and decrement requests. x0 is never tracked.
   // A writeback to a counter that is already zero is ignored.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_sb
         if (gi == 0) begin : g_x0
            assign inc_vec[gi] = 1'b0;
            assign dec_vec[gi] = 1'b0;
         end else begin : g_xn
            assign inc_vec[gi] = issue && wen_reg && (dst_reg == 5'(gi));
            assign dec_vec[gi] = wb_valid && (wb_dst == 5'(gi)) && (cnt_reg[gi] != '0);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            cnt_reg[i] <= '0;
         end
      end else begin
         // An issue and a writeback to the same register in one cycle cancel out.
         for (int i = 1; i < 32; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               cnt_reg[i] <= cnt_reg[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i]) begin
               cnt_reg[i] <= cnt_reg[i] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_EMPTY;
         ra1_reg     <= '0;
         ra2_reg     <= '0;
         use_ra1_reg <= 1'b0;
         use_ra2_reg <= 1'b0;
         wen_reg     <= 1'b0;
         dst_reg     <= '0;
      end else begin
         if (flush) begin
            state_reg <= ST_EMPTY;
         end else if (accept) begin
            state_reg <= ST_HELD;
         end else if (issue) begin
            state_reg <= ST_EMPTY;
         end
         if (accept) begin
            ra1_reg     <= in_ra1;
            ra2_reg     <= in_ra2;
            use_ra1_reg <= in_use_ra1;
            use_ra2_reg <= in_use_ra2;
            wen_reg     <= in_wen;
            dst_reg     <= in_dst;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_reg <= '0;
      end else if (held && !issue && !flush) begin
         stall_reg <= stall_reg + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Testbench for decode_issue_ctrl: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_decode_issue_ctrl;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int SAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_ra1 = '0;
   logic [4:0]  in_ra2 = '0;
   logic        in_use_ra1 = 1'b0;
   logic        in_use_ra2 = 1'b0;
   logic        in_wen = 1'b0;
   logic [4:0]  in_dst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_dst = '0;
   logic        flush = 1'b0;
   logic        hazard;
   logic [31:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   decode_issue_ctrl #(.CNT_W(2), .PERF_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ra1(in_ra1), .in_ra2(in_ra2),
      .in_use_ra1(in_use_ra1), .in_use_ra2(in_use_ra2),
      .in_wen(in_wen), .in_dst(in_dst),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_valid(wb_valid), .wb_dst(wb_dst),
      .flush(flush), .hazard(hazard), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic int sb(input int r);
      return int'(dut.cnt_reg[r]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      wb_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic offer(input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic u1, input logic u2,
                        input logic w, input logic [4:0] d);
      in_valid = 1'b1;
      in_ra1 = ra1; in_ra2 = ra2;
      in_use_ra1 = u1; in_use_ra2 = u2;
      in_wen = w; in_dst = d;
   endtask

   task automatic do_reset();
      idle();
      out_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
      tick();
      reset = 1'b0;
      $display("reset done");
   endtask

   task automatic test_independent();
      do_reset();
      out_ready = 1'b1;
      offer(0, 0, 0, 0, 1, 5);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready0 got=%b exp=1", in_ready); end
      tick();
      for (int k = 6; k <= 8; k++) begin
         if (k <= 7) offer(0, 0, 0, 0, 1, 5'(k)); else idle();
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL indep_issue_x%0d got=%b exp=1", k - 1, out_valid); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready_x%0d got=%b exp=1", k - 1, in_ready); end
         $display("indep issue dst=x%0d", k - 1);
         tick();
      end
      @(negedge clk);
      for (int r = 5; r <= 7; r++) begin
         checks++; if (sb(r) != 1) begin errors++; $display("FAIL indep_cnt_x%0d got=%0d exp=1", r, sb(r)); end
      end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL indep_stall got=%0d exp=0", stall_cycles); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL indep_empty got=%b exp=0", out_valid); end
      tick();
   endtask

   task automatic test_raw();
      do_reset();
      out_ready = 1'b1;
      offer(0, 0, 0, 0, 1, 5);          // cycle 1: producer accepted
      tick();
      offer(5, 0, 1, 0, 0, 0);          // cycle 2: producer issues, consumer accepted
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_prod_issue got=%b exp=1", out_valid); end
      tick();
      idle();                           // cycle 3: consumer waits on x5
      @(negedge clk);
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_c3_hazard got=%b exp=1", hazard); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_c3_valid got=%b exp=0", out_valid); end
      tick();
      wb_valid = 1'b1; wb_dst = 5'd5;   // cycle 4: x5 retires
      @(negedge clk);
      checks++; if (hazard !== !BYP) begin errors++; $display("FAIL raw_c4_hazard got=%b exp=%b", hazard, !BYP); end
      checks++; if (out_valid !== BYP) begin errors++; $display("FAIL raw_c4_valid got=%b exp=%b", out_valid, BYP); end
      tick();
      wb_valid = 1'b0;
      if (!BYP) begin                   // cycle 5: counter is 0
         @(negedge clk);
         checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_c5_hazard got=%b exp=0", hazard); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_c5_valid got=%b exp=1", out_valid); end
         tick();
      end
      @(negedge clk);
      checks++; if (stall_cycles !== (BYP ? 32'd1 : 32'd2)) begin errors++; $display("FAIL raw_stall got=%0d exp=%0d", stall_cycles, BYP ? 1 : 2); end
      checks++; if (sb(5) != 0) begin errors++; $display("FAIL raw_cnt_x5 got=%0d exp=0", sb(5)); end
      $display("raw consumer issued");
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         offer(0, 0, 0, 0, 1, 8);
         tick();
      end
      idle();
      @(negedge clk);
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sat_hazard got=%b exp=1", hazard); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_ready got=%b exp=0", in_ready); end
      checks++; if (sb(8) != SAT) begin errors++; $display("FAIL sat_cnt_full got=%0d exp=%0d", sb(8), SAT); end
      tick();
      wb_valid = 1'b1; wb_dst = 5'd8;
      @(negedge clk);
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sat_wb_hazard got=%b exp=1", hazard); end
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_issue got=%b exp=1", out_valid); end
      checks++; if (sb(8) != 2) begin errors++; $display("FAIL sat_cnt_dec got=%0d exp=2", sb(8)); end
      tick();
      @(negedge clk);
      checks++; if (sb(8) != SAT) begin errors++; $display("FAIL sat_cnt_back got=%0d exp=%0d", sb(8), SAT); end
      $display("sat fourth write issued");
      tick();
   endtask

   task automatic test_simul();
      do_reset();
      out_ready = 1'b1;
      offer(0, 0, 0, 0, 1, 9);
      tick();
      offer(0, 0, 0, 0, 1, 9);
      tick();
      idle();
      wb_valid = 1'b1; wb_dst = 5'd9;   // second x9 issues as the first retires
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_issue got=%b exp=1", out_valid); end
      tick();
      wb_dst = 5'd10;                   // x10 has nothing in flight
      @(negedge clk);
      checks++; if (sb(9) != 1) begin errors++; $display("FAIL simul_cnt_x9 got=%0d exp=1", sb(9)); end
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      checks++; if (sb(10) != 0) begin errors++; $display("FAIL simul_cnt_x10 got=%0d exp=0", sb(10)); end
      $display("simul done");
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b1;
      offer(0, 0, 0, 0, 1, 5);
      tick();
      idle();
      tick();
      offer(5, 0, 1, 0, 0, 0);
      tick();
      offer(0, 0, 0, 0, 1, 6);
      flush = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      tick();
      idle();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid got=%b exp=0", out_valid); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_after_hazard got=%b exp=0", hazard); end
      checks++; if (sb(5) != 1) begin errors++; $display("FAIL flush_cnt_x5 got=%0d exp=1", sb(5)); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL flush_stall got=%0d exp=0", stall_cycles); end
      $display("flush dropped held instr");
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b1;
      offer(0, 0, 0, 0, 1, 5);
      tick();
      offer(5, 0, 1, 0, 0, 0);
      tick();
      idle();
      tick();
      tick();
      checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL areset_pre_stall got=%0d exp=2", stall_cycles); end
      #1 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL areset_hazard got=%b exp=0", hazard); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b exp=1", in_ready); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL areset_stall got=%0d exp=0", stall_cycles); end
      checks++; if (sb(5) != 0) begin errors++; $display("FAIL areset_cnt_x5 got=%0d exp=0", sb(5)); end
      #1 reset = 1'b0;
      $display("async reset done");
      tick();
   endtask

   // ---------------- randomized run against a reference model ----------------
   typedef struct {
      logic [4:0] ra1, ra2, dst;
      bit u1, u2, w;
   } instr_t;

   instr_t      slot_q[$];
   int          m_cnt[32];
   logic [31:0] m_stall;

   function automatic bit src_busy(input logic [4:0] r, input bit u);
      if (!u || r == 5'd0 || m_cnt[r] == 0) return 1'b0;
      if (BYP && m_cnt[r] == 1 && wb_valid && wb_dst == r) return 1'b0;
      return 1'b1;
   endfunction

   task automatic test_random();
      instr_t h;
      instr_t n;
      bit held, blocked, e_hz, e_ov, e_ir, iss;
      int cand[$];
      do_reset();
      slot_q = {};
      m_stall = '0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_ra1     = 5'($urandom_range(0, 7));
         in_ra2     = 5'($urandom_range(0, 7));
         in_use_ra1 = 1'($urandom_range(0, 1));
         in_use_ra2 = 1'($urandom_range(0, 1));
         in_wen     = ($urandom_range(0, 3) != 0);
         in_dst     = 5'($urandom_range(0, 7));
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         cand = {};
         for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) cand.push_back(r);
         if (cand.size() > 0 && $urandom_range(0, 9) < 5) begin
            wb_valid = 1'b1;
            wb_dst = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end else if ($urandom_range(0, 19) == 0) begin
            wb_valid = 1'b1;
            wb_dst = 5'($urandom_range(0, 7));
         end else begin
            wb_valid = 1'b0;
         end
         @(negedge clk);
         held = (slot_q.size() != 0);
         blocked = 1'b0;
         if (held) begin
            h = slot_q[0];
            blocked = src_busy(h.ra1, h.u1) || src_busy(h.ra2, h.u2) ||
                      (h.w && h.dst != 5'd0 && m_cnt[h.dst] == SAT);
         end
         e_hz = held && blocked;
         e_ov = held && !blocked && !flush;
         iss  = e_ov && out_ready;
         e_ir = !flush && (!held || iss);
         checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov); end
         checks++; if (hazard !== e_hz) begin errors++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, hazard, e_hz); end
         checks++; if (in_ready !== e_ir) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ir); end
         checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cycles, m_stall); end
         for (int r = 0; r < 8; r++) begin
            checks++; if (sb(r) != m_cnt[r]) begin errors++; $display("FAIL rnd_cnt_x%0d cyc=%0d got=%0d exp=%0d", r, cyc, sb(r), m_cnt[r]); end
         end
         if (iss) $display("rnd issue cyc=%0d dst=x%0d wen=%0d", cyc, h.dst, h.w);
         // advance the model by one clock
         if (held && !iss && !flush) m_stall = m_stall + 32'd1;
         if (wb_valid && wb_dst != 5'd0 && m_cnt[wb_dst] > 0) m_cnt[wb_dst]--;
         if (iss && h.w && h.dst != 5'd0) m_cnt[h.dst]++;
         if (iss || flush) void'(slot_q.pop_front());
         if (in_valid && e_ir) begin
            n.ra1 = in_ra1; n.ra2 = in_ra2; n.dst = in_dst;
            n.u1 = in_use_ra1; n.u2 = in_use_ra2; n.w = in_wen;
            slot_q.push_back(n);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_saturation();
      test_simul();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Issue controller between the fetch/decode boundary and execute in the 64-bit RISC-V pipeline.
- Holds one decoded instruction in an issue slot and tracks in-flight destination registers in a per-register counter scoreboard.
- Releases the instruction to execute only when its source registers are free and execute is ready.
- Also handles pipeline flush and keeps a stall performance counter.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; at most 2^CNT_W-1 writes to one register in flight.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a decoded instruction is offered.
- in_ready  out  1  issue slot can accept.
- in_ra1  in  5  source register 1.
- in_ra2  in  5  source register 2.
- in_use_ra1  in  1  instruction reads ra1.
- in_use_ra2  in  1  instruction reads ra2.
- in_wen  in  1  instruction writes a register.
- in_dst  in  5  destination register.
- out_valid  out  1  held instruction is issued this cycle if out_ready.
- out_ready  in  1  execute accepts.
- wb_valid  in  1  one register write is retiring (including squashed in-flight ops).
- wb_dst  in  5  retiring destination.
- flush  in  1  drop the held, unissued instruction.
- hazard  out  1  held instruction is blocked by the scoreboard.
- stall_cycles  out  PERF_W  cycles with a held instruction that is not issued.

Behaviour:
- Reset values: slot empty; all scoreboard counters 0; stall_cycles 0; out_valid 0; hazard 0; in_ready 1.
- Slot states: EMPTY and HELD.
  - EMPTY->HELD on in_valid&&in_ready&&!flush.
  - HELD->EMPTY on issue without a new accept, or on flush.
  - HELD->HELD on issue plus accept in the same cycle (back-to-back).
- Held fields (ra1, ra2, use bits, wen, dst) are registered at accept. Minimum latency: accept at cycle t gives out_valid at t+1.
- A source is busy when its use bit is 1, it is not x0, and its counter is nonzero.
- The destination blocks when wen is 1, dst is not x0, and its counter is saturated (2^CNT_W-1).
- hazard = HELD && (ra1 busy || ra2 busy || dst blocks).
- out_valid = HELD && !hazard && !flush.
- issue = out_valid && out_ready.
- in_ready = !flush && (EMPTY || issue). This is combinational, so there is no bubble on a full pipeline.
- Scoreboard increments on issue when wen is 1 and dst is not x0. It decrements on wb_valid when wb_dst is not x0.
- Issue and wb to the same register in the same cycle: net counter change 0.
- wb_valid to a register whose counter is 0 is ignored; the counter saturates at 0 and never wraps.
- x0 is never tracked; its counter stays 0.
- flush has priority: the held instruction is dropped, nothing is accepted that cycle, and the scoreboard is not modified by flush. Already-issued squashed ops release their registers through wb_valid.
- stall_cycles increments each cycle HELD && !issue && !flush, and wraps at 2^PERF_W.
- Asserting reset mid-operation returns all state to reset values immediately, independent of clk.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a source whose counter equals 1 is treated as not busy when wb_valid && wb_dst matches it in the same cycle, so the consumer issues in the writeback cycle. Execute forwards the writeback value.
- Not defined: a source is busy while its counter is nonzero. The consumer issues the cycle after the counter reaches 0.

Test Plan:
- Reset then independent stream: offer instructions with wen=1 and dst x5, x6, x7 and out_ready=1 -> one issue per cycle, counters x5/x6/x7 = 1, stall_cycles = 0.
- RAW stall: issue dst=x5, then an instruction with use_ra1=1 and ra1=x5; wb_valid with wb_dst=x5 at cycle 4 -> hazard=1 until the counter clears; issue at cycle 5 without WB_BYPASS_EN, at cycle 4 with it; stall_cycles matches.
- Saturation, CNT_W=2: issue three writes to x8 -> a fourth dst=x8 holds with hazard=1; one wb to x8 -> it issues next cycle, counter returns to 3.
- Simultaneous issue and wb to x9 with counter 1 -> counter stays 1; wb to x10 with counter 0 -> counter stays 0.
- Flush: slot HELD and blocked on x5, flush=1 with in_valid=1 -> slot EMPTY, nothing accepted, in_ready=0 that cycle, x5 counter unchanged, out_valid=0.
- Async reset while HELD with nonzero counters -> all outputs return to reset values before the next clk edge.
